via_timer_bank: RTL

Parametrised multi-channel interval-timer block with 6522-style programming semantics: NUM_TIMERS independent down-counters with 8-bit latch/counter access, one-shot or free-running mode, per-channel square-wave output, and a shared VIA-style IFR/IER interrupt pair. It sits on the same 8-bit peripheral bus and phi2 enable strobes as the VIA core. It serves mockingboard/sound-card and general timing functions that need more than two timers or widths other than 16 bits.

---
 rtl/via_timer_pkg.sv | 22 ++
 rtl/via_timer_channel.sv | 111 +++++++++++
 rtl/via_timer_bank.sv | 120 ++++++++++++
 3 files changed

// File: rtl/via_timer_pkg.sv
// via_timer_pkg
// Shared register offsets, MODE bit positions and the per-channel mode record
// for the via_timer_bank multi-channel interval timer.
package via_timer_pkg;

    // Register offsets on the 5-bit peripheral address bus.
    // Channel n counter/latch bytes sit at 2n (lo) and 2n+1 (hi).
    localparam logic [4:0] REG_IFR       = 5'h10;
    localparam logic [4:0] REG_IER       = 5'h11;
    localparam logic [4:0] REG_MODE_BASE = 5'h18;

    // Bit positions inside a MODE register.
    localparam int MODE_CONT  = 0;
    localparam int MODE_OUTEN = 1;

    // Field order matches the bit positions above (cont is bit 0).
    typedef struct packed {
        logic outen;
        logic cont;
    } mode_t;

endpackage

// File: rtl/via_timer_channel.sv
// via_timer_channel
// One down-counting interval timer with a write latch, an arm flag for
// one-shot interrupts, a MODE register and a square-wave output.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   tick           phi2 rising-edge enable; one count per tick
//   lo_we, hi_we   bus write strobes for the latch low / high byte
//   mode_we        bus write strobe for the MODE register
//   wdata          bus write data
//   count_o        current counter value
//   mode_o         current MODE bits {outen, cont}
//   flag_set_o     request to set this channel's IFR bit (combinational)
//   timer_out_o    square-wave output
module via_timer_channel
    import via_timer_pkg::*;
#(
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   lo_we,
    input  logic                   hi_we,
    input  logic                   mode_we,
    input  logic [7:0]             wdata,
    output logic [TIMER_WIDTH-1:0] count_o,
    output logic [1:0]             mode_o,
    output logic                   flag_set_o,
    output logic                   timer_out_o
);

    localparam int HI_W = TIMER_WIDTH - 8;

    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] latch_q, latch_d;
    logic                   armed_q, armed_d;
    logic                   tout_q,  tout_d;
    mode_t                  mode_q,  mode_d;

    always_comb begin
        count_d    = count_q;
        latch_d    = latch_q;
        armed_d    = armed_q;
        tout_d     = tout_q;
        mode_d     = mode_q;
        flag_set_o = 1'b0;

        if (lo_we) begin
            latch_d[7:0] = wdata;
        end
        // Unimplemented high-byte bits are simply dropped here.
        if (hi_we) begin
            latch_d[TIMER_WIDTH-1:8] = wdata[HI_W-1:0];
        end

        // A hi write beats a coincident tick: the load happens and that
        // tick is not counted.
        if (hi_we) begin
            count_d = latch_d;
            armed_d = 1'b1;
        end else if (tick) begin
            if (count_q == '0) begin
                if (mode_q.cont) begin
                    // Reload from the latch as it stood before this edge.
                    count_d    = latch_q;
                    flag_set_o = 1'b1;
                end else begin
                    // One-shot keeps counting through the wrap but only
                    // interrupts once per arming.
                    count_d    = '1;
                    flag_set_o = armed_q;
                    armed_d    = 1'b0;
                end
                if (mode_q.outen) begin
                    tout_d = ~tout_q;
                end
            end else begin
                count_d = count_q - TIMER_WIDTH'(1);
            end
        end

        // Mode changes land after this edge's count decision, so they
        // affect the next tick onwards.
        if (mode_we) begin
            mode_d.cont  = wdata[MODE_CONT];
            mode_d.outen = wdata[MODE_OUTEN];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            latch_q <= '0;
            armed_q <= 1'b0;
            tout_q  <= 1'b0;
            mode_q  <= '0;
        end else begin
            count_q <= count_d;
            latch_q <= latch_d;
            armed_q <= armed_d;
            tout_q  <= tout_d;
            mode_q  <= mode_d;
        end
    end

    assign count_o     = count_q;
    assign mode_o      = mode_q;
    assign timer_out_o = tout_q;

endmodule

// File: rtl/via_timer_bank.sv
// via_timer_bank
// Bank of NUM_TIMERS 6522-style interval timers on an 8-bit peripheral bus,
// sharing one IFR/IER interrupt pair.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset
//   rising     phi2 rising-edge enable; the count tick
//   falling    phi2 falling-edge enable; reserved, unused
//   addr       register address
//   wen, ren   single-cycle bus write / read strobes
//   data_in    bus write data
//   data_out   read data, combinational from addr
//   timer_out  per-channel square-wave outputs
//   irq        OR over channels of IFR & IER
module via_timer_bank
    import via_timer_pkg::*;
#(
    parameter int NUM_TIMERS  = 4,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rising,
    input  logic                  falling,
    input  logic [4:0]            addr,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic [NUM_TIMERS-1:0] timer_out,
    output logic                  irq
);

    logic [NUM_TIMERS-1:0]  lo_we, hi_we, mode_we, rd_clr, flag_set;
    logic [NUM_TIMERS-1:0]  ifr_q, ifr_d;
    logic [NUM_TIMERS-1:0]  ier_q, ier_d;
    logic [TIMER_WIDTH-1:0] count [NUM_TIMERS];
    logic [1:0]             mode  [NUM_TIMERS];

    logic unused_falling;
    assign unused_falling = falling;

    for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
        assign lo_we[n]   = wen && (addr == 5'(2 * n));
        assign hi_we[n]   = wen && (addr == 5'(2 * n + 1));
        assign mode_we[n] = wen && (addr == REG_MODE_BASE + 5'(n));
        // A write in the same cycle suppresses the read side effect.
        assign rd_clr[n]  = ren && !wen && (addr == 5'(2 * n));

        via_timer_channel #(
            .TIMER_WIDTH(TIMER_WIDTH)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .tick       (rising),
            .lo_we      (lo_we[n]),
            .hi_we      (hi_we[n]),
            .mode_we    (mode_we[n]),
            .wdata      (data_in),
            .count_o    (count[n]),
            .mode_o     (mode[n]),
            .flag_set_o (flag_set[n]),
            .timer_out_o(timer_out[n])
        );
    end

    always_comb begin
        ifr_d = ifr_q;
        if (wen && addr == REG_IFR) begin
            ifr_d = ifr_d & ~data_in[NUM_TIMERS-1:0];
        end
        ifr_d = ifr_d & ~(hi_we | rd_clr);
        // Applied last so an underflow wins over any clear in the same cycle.
        ifr_d = ifr_d | flag_set;

        ier_d = ier_q;
        if (wen && addr == REG_IER) begin
            if (data_in[7]) begin
                ier_d = ier_q | data_in[NUM_TIMERS-1:0];
            end else begin
                ier_d = ier_q & ~data_in[NUM_TIMERS-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifr_q <= '0;
            ier_q <= '0;
        end else begin
            ifr_q <= ifr_d;
            ier_q <= ier_d;
        end
    end

    assign irq = |(ifr_q & ier_q);

    always_comb begin
        data_out = 8'h00;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (addr == 5'(2 * n)) begin
                data_out = count[n][7:0];
            end
            if (addr == 5'(2 * n + 1)) begin
                data_out = 8'(count[n][TIMER_WIDTH-1:8]);
            end
            if (addr == REG_MODE_BASE + 5'(n)) begin
                data_out = {6'b0, mode[n]};
            end
        end
        if (addr == REG_IFR) begin
            data_out = {irq, 7'(ifr_q)};
        end
        if (addr == REG_IER) begin
            data_out = {1'b1, 7'(ier_q)};
        end
    end

endmodule
